// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// serial_subtractor: bit-serial WIDTH-bit subtractor, one full-subtractor
// slice per clock (LSB first) with the borrow chained through a flop.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - request, sampled only in IDLE
//   a, b  - minuend / subtrahend, captured on the accepted start edge
//   bin   - initial borrow-in, captured on the accepted start edge
//   busy  - high while in RUN
//   done  - one-cycle pulse when diff/bout are updated
//   diff  - (a - b - bin) mod 2^WIDTH
//   bout  - final borrow, 1 iff a < b + bin
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d_c;
  logic             nb_c;
  logic             last_c;

  // Full-subtractor slice on the current operand LSBs and stored borrow
  always_comb begin
    d_c    = a_sr[0] ^ b_sr[0] ^ br;
    nb_c   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    last_c = (cnt == CW'(WIDTH - 1));
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_c) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register, status flags and datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state == RUN);
      done  <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            br   <= bin;
            res  <= '0;
            cnt  <= '0;
          end
        end
        RUN: begin
          // Result fills from the MSB so bit 0 lands in place after WIDTH shifts
          res  <= {d_c, res[WIDTH-1:1]};
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          br   <= nb_c;
          if (last_c) begin
            diff <= {d_c, res[WIDTH-1:1]};
            bout <= nb_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mbin);
    int av, bv, dv;
    av = int'(ma);
    bv = int'(mb) + int'(mbin);
    dv = (av - bv) & ((1 << W) - 1);
    return {(av < bv) ? 1'b1 : 1'b0, dv[W-1:0]};
  endfunction

  // One isolated operation with latency, busy-length and hold checks
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                       input logic [W-1:0] ed, input logic eb, input string nm);
    int lat;
    int bc;
    logic stable;
    logic [W-1:0] prev;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    prev = diff;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = ~tb_v; bin = ~tbin;
    lat = 0;
    bc = busy ? 1 : 0;
    stable = 1'b1;
    while (!done && lat < 30) begin
      if (diff !== prev) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (!done && busy) bc++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd8);
    chk({nm, "_busy_cycles"}, 32'(bc), 32'd8);
    chk({nm, "_diff_hold"}, 32'(stable), 32'd1);
    chk({nm, "_diff"}, 32'(diff), 32'(ed));
    chk({nm, "_bout"}, 32'(bout), 32'(eb));
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dcount;
    int w;
    int last_done;
    logic [W:0] expq[$];
    logic [W:0] e;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0};
    vecs[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_bout,
            $sformatf("vec%0d", i));

    // Start pulse and operand change mid-run must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; a = 8'hFF; b = 8'hFF; bin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcount = 0;
    e = '0;
    for (int k = 0; k < 14; k++) begin
      if (done) begin
        dcount++;
        e = {bout, diff};
      end
      @(posedge clk); #1;
    end
    chk("ign_done_count", 32'(dcount), 32'd1);
    chk("ign_diff", 32'(e[W-1:0]), 32'h0F);
    chk("ign_bout", 32'(e[W]), 32'd0);

    // Reset mid-run after a result with nonzero diff and bout
    do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "pre_rst");
    @(negedge clk);
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("midrst_no_done", 32'(dcount), 32'd0);
    do_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "post_rst");

    // Random back-to-back with start held high
    @(negedge clk);
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    expq.push_back(model(a, b, bin));
    start = 1'b1;
    last_done = 0;
    for (int i = 0; i < 1000; i++) begin
      w = 0;
      do begin
        @(posedge clk); #1;
        w++;
      end while (!done && w < 30);
      if (!done) begin
        chk("rand_timeout", 32'd0, 32'd1);
        break;
      end
      e = expq.pop_front();
      chk($sformatf("rand%0d_result", i), 32'({bout, diff}), 32'(e));
      if (i > 0) chk($sformatf("rand%0d_spacing", i), 32'(cyc - last_done), 32'd10);
      last_done = cyc;
      if (i < 999) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        expq.push_back(model(a, b, bin));
      end
    end
    start = 1'b0;
    repeat (12) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor built around a single full-subtractor slice plus a registered borrow. It accepts two unsigned operands and an initial borrow, then processes one bit per clock, LSB first. It presents the WIDTH-bit difference and the final borrow with a one-cycle done pulse. It sits directly downstream of the combinational full subtractor: it consumes that cell's D/Bout each cycle and chains the borrow through a flop instead of a ripple.

## Interface

- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- bin  input  1  initial borrow-in; captured on the accepted start edge.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse when diff/bout are updated.
- diff  output  WIDTH  result, (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned).

## Operation

- States: IDLE, RUN, DONE.
  - IDLE: start=1 → latch a, b, bin into the shift registers and borrow flop; clear the bit counter; go to RUN. start=0 → stay.
  - RUN: each edge takes the LSBs a0 and b0 and the borrow register br, computes d = a0^b0^br and nb = (~a0&b0) | (~(a0^b0)&br), shifts d into the MSB of the internal result register, shifts the operand registers right by one, sets br←nb, and increments the counter. On the edge that processes bit WIDTH-1: load diff from the completed result, load bout←nb, and go to DONE.
  - DONE: done=1 for exactly this cycle; unconditionally return to IDLE on the next edge.
- start is ignored in RUN and DONE; there is no queueing. start held high continuously causes back-to-back operations, with one IDLE cycle between done and the next capture.
- Operand changes on a, b, bin after capture have no effect on the operation in flight.
- diff and bout change only on the final RUN edge and hold their values until the next operation completes. Partial results are never visible on diff.
- Bit counter width is $clog2(WIDTH); the counter is compared against WIDTH-1 and never wraps past it.
- Reset, asserted at any time including mid-RUN: state→IDLE; busy=0, done=0, diff=0, bout=0; internal registers and counter are cleared. The aborted operation produces no done pulse.

## Timing

- Reset values: busy=0, done=0, diff=0, bout=0, state=IDLE.
- Start accepted at edge E0: busy=1 from E0 until E(WIDTH).
- Bits 0..WIDTH-1 are processed at edges E1..E(WIDTH).
- At edge E(WIDTH): diff/bout are updated, busy=0, and done=1 during the cycle E(WIDTH)..E(WIDTH+1).
- Latency from accepted start to done = WIDTH cycles. Throughput = one result per WIDTH+2 cycles.
- Earliest next accepted start is at edge E(WIDTH+2).
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan

All scenarios use WIDTH=8.

- Basic: a=0x5A, b=0x3C, bin=0 → diff=0x1E, bout=0. done pulses exactly 8 cycles after the start edge. busy is high for 8 cycles.
- Underflow: a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1.
- Borrow-in chain: a=0xFF, b=0xFF, bin=1 → diff=0xFF, bout=1. Second case: a=0x80, b=0x00, bin=1 → diff=0x7F, bout=0.
- Ignored start: pulse start and change a/b at cycle 3 of an operation with a=0x10, b=0x01, bin=0 → result stays diff=0x0F, bout=0. Exactly one done pulse occurs.
- Reset mid-op: assert rst at cycle 4 of a RUN → busy, done, diff and bout go to 0 immediately (asynchronously) and no done pulse follows. A new start after release gives correct results.
- Random/exhaustive: 1000 random (a, b, bin) triples with start held high → every done matches {bout, diff} = {a < b+bin, (a-b-bin) & 0xFF}. Spacing between successive done pulses = 10 cycles.
